branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Program-counter stage directly downstream of the immediate shifter.
- Consumes the shifted branch offset (`shiftImmediate`, already `immediate << 2`) and forms the branch target `branchPc + shiftImmediate`.
- Selects between sequential PC+4 and the branch target, and holds the PC register.
- Inserts one fetch bubble after every taken branch; supports pipeline stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  1 = hold all state this cycle
- branch  input  1  1 = taken branch/jump resolved this cycle
- branchPc  input  32  PC of the resolving branch instruction
- shiftImmediate  input  32  shifted offset from the immediate shifter
- pc  output  32  current fetch address (registered)
- pcPlus4  output  32  pc + PC_STEP (combinational, mod 2^32)
- fetchValid  output  1  1 = instruction fetched at pc is valid
- branchTarget  output  32  branchPc + shiftImmediate (combinational, mod 2^32)

Behaviour:
- Interface (already decided): one clock, `clock`; reset is asynchronous and active-low, `reset`.
- Reset (`reset`=0, async):
  - pc = RESET_PC.
  - state = BOOT.
  - fetchValid = 0.
  - Optional counter = 0.
  - Reset asserted in any state, including mid-REDIRECT, aborts immediately; no pending branch survives.
- FSM states: BOOT, RUN, REDIRECT. fetchValid = 1 only in RUN (decoded from the state register, no combinational path from inputs).
- BOOT:
  - stall=0 → RUN; pc holds RESET_PC, so the first valid fetch is at RESET_PC.
  - stall=1 → remain in BOOT.
  - branch is ignored.
- RUN, priority stall > branch > sequential:
  - stall=1: pc and state hold; branch is ignored, and upstream must keep it asserted.
  - branch=1: pc <= branchTarget; state <= REDIRECT.
  - otherwise: pc <= pc + PC_STEP.
- REDIRECT (one bubble cycle, fetchValid=0):
  - stall=0 → RUN with pc held, so the target is fetched as valid the next cycle.
  - stall=1 → remain in REDIRECT.
  - branch is ignored.
- Latency:
  - branch sampled at edge N → pc = target after edge N.
  - fetchValid=0 from edge N to N+1.
  - fetchValid=1 with pc = target after edge N+1.
- Arithmetic: all adds 32-bit, wrap modulo 2^32, no overflow flag.
  - Negative offsets are two's complement (e.g. shiftImmediate = 32'hFFFF_FFF8 moves back 8).
  - pc = 32'hFFFF_FFFC sequential → 32'h0000_0000.
- No alignment check: shiftImmediate is always a multiple of 4 by construction, and RESET_PC/PC_STEP are aligned.

Optional Feature:
- Macro: BRANCH_COUNT_EN.
- Defined:
  - Adds output `branchCount` [15:0], reset 0.
  - Increments on every accepted taken branch (RUN, stall=0, branch=1).
  - Saturates at 16'hFFFF.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, stall=0 → cycle 1 pc=0, fetchValid=0 (BOOT); cycle 2 pc=0, fetchValid=1; cycle 3 pc=4; cycle 4 pc=8.
- In RUN with pc=0x10, branch=1, branchPc=0x0C, shiftImmediate=0x20 → next pc=0x2C, fetchValid=0; following cycle pc=0x2C, fetchValid=1; then pc=0x30.
- branch=1, branchPc=0x100, shiftImmediate=32'hFFFF_FFF0 → pc=0xF0 after one bubble; pc=32'hFFFF_FFFC sequential → 0x0.
- stall=1 for 3 cycles in RUN with pc=0x40, branch=1 → pc stays 0x40, fetchValid stays 1; stall drops → pc=target, bubble; stall held during REDIRECT → bubble extends.
- reset pulsed low asynchronously mid-REDIRECT (between edges) → pc=RESET_PC and fetchValid=0 immediately; BOOT sequence repeats.
- With BRANCH_COUNT_EN: 3 taken branches plus 1 stalled branch → branchCount=3; force count to 16'hFFFF, take a branch → stays 16'hFFFF.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program-counter stage that follows the immediate shifter.
// Forms branchTarget = branchPc + shiftImmediate, selects between pc + PC_STEP
// and the branch target, and inserts one fetch bubble after each taken branch.
// Optional feature macro: BRANCH_COUNT_EN adds the saturating branchCount output.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   stall          1 = hold all state this cycle
//   branch         1 = taken branch/jump resolved this cycle
//   branchPc       PC of the resolving branch instruction
//   shiftImmediate shifted branch offset (immediate << 2)
//   pc             current fetch address (registered)
//   pcPlus4        pc + PC_STEP (combinational)
//   fetchValid     1 = fetch at pc is valid (decoded from the state register)
//   branchTarget   branchPc + shiftImmediate (combinational)
//   branchCount    accepted taken branches, saturating (BRANCH_COUNT_EN only)
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branchPc,
  input  logic [31:0] shiftImmediate,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchValid,
  output logic [31:0] branchTarget
`ifdef BRANCH_COUNT_EN
  ,
  output logic [15:0] branchCount
`endif
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] seq_pc;

  // Adders wrap modulo 2^32 by width truncation.
  assign target = PC_W'(branchPc + shiftImmediate);
  assign seq_pc = PC_W'(pc_q + PC_STEP);

`ifdef BRANCH_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;
`endif

  // Next-state and next-pc selection; stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef BRANCH_COUNT_EN
    count_d = count_q;
`endif
    case (state_q)
      BOOT: begin
        if (!stall) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (branch) begin
            pc_d    = target;
            state_d = REDIRECT;
`ifdef BRANCH_COUNT_EN
            if (count_q != {CNT_W{1'b1}}) count_d = CNT_W'(count_q + CNT_W'(1));
`endif
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      REDIRECT: begin
        // Bubble cycle: pc already holds the target, fetch it next cycle.
        if (!stall) state_d = RUN;
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // State, pc and optional counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
`ifdef BRANCH_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef BRANCH_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign pc           = pc_q;
  assign pcPlus4      = seq_pc;
  assign branchTarget = target;
  assign fetchValid   = (state_q == RUN);
`ifdef BRANCH_COUNT_EN
  assign branchCount  = count_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, hand-written
// reset/stall sequences, then randomized traffic against a reference model.
module tb_branch_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [31:0] branchPc;
  logic [31:0] shiftImmediate;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic [31:0] branchTarget;
`ifdef BRANCH_COUNT_EN
  logic [15:0] branchCount;
`endif

  branch_pc_unit dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .branch         (branch),
    .branchPc       (branchPc),
    .shiftImmediate (shiftImmediate),
    .pc             (pc),
    .pcPlus4        (pcPlus4),
    .fetchValid     (fetchValid),
    .branchTarget   (branchTarget)
`ifdef BRANCH_COUNT_EN
    ,
    .branchCount    (branchCount)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the fetch address and whether it is valid. Any
  // non-valid cycle (boot or bubble) becomes valid at the same pc once
  // unstalled; a valid cycle either advances by 4 or jumps to the target.
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_cnt;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] bp;
    logic [31:0] imm;
    logic [31:0] exp_pc;
    logic        exp_v;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // Apply one cycle of inputs; returns just after the following negedge.
  task automatic step(input logic s, input logic b, input logic [31:0] bp, input logic [31:0] imm);
    stall          = s;
    branch         = b;
    branchPc       = bp;
    shiftImmediate = imm;
    #1;
    chk("branchTarget", branchTarget, bp + imm);
    @(posedge clock);
    if (!s) begin
      if (!m_valid) m_valid = 1'b1;
      else if (b) begin
        m_pc    = bp + imm;
        m_valid = 1'b0;
        if (m_cnt < 65535) m_cnt++;
      end else m_pc = m_pc + 32'd4;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    branch = 1'b0;
    branchPc = '0;
    shiftImmediate = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(fetchValid), 32'h0);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};
    tv[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h4,        1'b1};
    tv[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h8,        1'b1};
    tv[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'hC,        1'b1};
    tv[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h10,       1'b1};
    tv[5]  = '{1'b0, 1'b1, 32'hC,   32'h20,       32'h2C,       1'b0};
    tv[6]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h2C,       1'b1};
    tv[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h30,       1'b1};
    tv[8]  = '{1'b0, 1'b1, 32'h100, 32'hFFFF_FFF0, 32'hF0,      1'b0};
    tv[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'hF0,       1'b1};
    tv[10] = '{1'b0, 1'b1, 32'h3C,  32'h4,        32'h40,       1'b0};
    tv[11] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h40,       1'b1};
    tv[12] = '{1'b1, 1'b1, 32'h40,  32'h100,      32'h40,       1'b1};
    tv[13] = '{1'b1, 1'b1, 32'h40,  32'h100,      32'h40,       1'b1};
    tv[14] = '{1'b1, 1'b1, 32'h40,  32'h100,      32'h40,       1'b1};
    tv[15] = '{1'b0, 1'b1, 32'h40,  32'h100,      32'h140,      1'b0};
    tv[16] = '{1'b1, 1'b1, 32'h0,   32'h800,      32'h140,      1'b0};
    tv[17] = '{1'b1, 1'b1, 32'h0,   32'h800,      32'h140,      1'b0};
    tv[18] = '{1'b0, 1'b1, 32'h0,   32'h800,      32'h140,      1'b1};
    tv[19] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h144,      1'b1};
    tv[20] = '{1'b0, 1'b1, 32'h0,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    tv[21] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'hFFFF_FFFC, 1'b1};
    tv[22] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};

    // Reset, then a stalled BOOT cycle with a (ignored) branch present.
    do_reset();
    step(1'b1, 1'b1, 32'h10, 32'h10);
    chk("boot_stall_pc", pc, 32'h0);
    chk("boot_stall_valid", 32'(fetchValid), 32'h0);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      step(tv[i].s, tv[i].b, tv[i].bp, tv[i].imm);
      chk($sformatf("tv%0d_pc", i), pc, tv[i].exp_pc);
      chk($sformatf("tv%0d_valid", i), 32'(fetchValid), 32'(tv[i].exp_v));
      chk($sformatf("tv%0d_pcPlus4", i), pcPlus4, tv[i].exp_pc + 32'd4);
    end
`ifdef BRANCH_COUNT_EN
    chk("count_table", 32'(branchCount), 32'd5);
`endif

    // Asynchronous reset between edges while in the redirect bubble.
    step(1'b0, 1'b1, 32'h200, 32'h40);
    chk("pre_arst_pc", pc, 32'h240);
    chk("pre_arst_valid", 32'(fetchValid), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", 32'(fetchValid), 32'h0);
`ifdef BRANCH_COUNT_EN
    chk("arst_count", 32'(branchCount), 32'h0);
`endif
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("reboot_pc0", pc, 32'h0);
    chk("reboot_valid", 32'(fetchValid), 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("reboot_pc4", pc, 32'h4);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic s, b;
      logic [31:0] bp, imm;
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 9) < 4);
      bp  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC)
                                       : (32'($urandom_range(0, 64)) << 2);
      step(s, b, bp, imm);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_valid", 32'(fetchValid), 32'(m_valid));
      chk("rnd_pcPlus4", pcPlus4, m_pc + 32'd4);
    end
`ifdef BRANCH_COUNT_EN
    chk("rnd_count", 32'(branchCount), 32'(m_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
